// File: rtl/vga_sync_gen_if.sv
// Scan-timing bundle from vga_sync_gen to the pixel pipeline and VGA connector.
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       tick;
    logic       ref_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] frame;

    modport master (
        output hsync, vsync, video_on, tick, ref_tick, pixel_x, pixel_y, frame
    );

    modport slave (
        input hsync, vsync, video_on, tick, ref_tick, pixel_x, pixel_y, frame
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v scan counters, frame counter
// and combinational sync/blank/frame-strobe decodes aligned to the counters.
module vga_sync_gen #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_DISP = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(DIV - 1);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync edge at exactly 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_DISP);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_DISP);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);

    logic [3:0]  div_cnt;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [7:0]  frame_q;
    logic        tick;
    logic        x_last;
    logic        y_last;
    logic [10:0] x_ext;
    logic [10:0] y_ext;

    assign tick   = (div_cnt == DIV_LAST);
    assign x_last = (px == X_LAST);
    assign y_last = (py == Y_LAST);
    assign x_ext  = {1'b0, px};
    assign y_ext  = {1'b0, py};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            px      <= '0;
            py      <= '0;
            frame_q <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 4'd1;
            if (tick) begin
                if (x_last) begin
                    px <= '0;
                    if (y_last) begin
                        py      <= '0;
                        frame_q <= frame_q + 8'd1;
                    end else begin
                        py <= py + 10'd1;
                    end
                end else begin
                    px <= px + 10'd1;
                end
            end
        end
    end

    assign vga.tick     = tick;
    assign vga.pixel_x  = px;
    assign vga.pixel_y  = py;
    assign vga.frame    = frame_q;
    assign vga.video_on = (x_ext < H_VIS) && (y_ext < V_VIS);
    assign vga.hsync    = !((x_ext >= HS_START) && (x_ext < HS_END));
    assign vga.vsync    = !((y_ext >= VS_START) && (y_ext < VS_END));
    // First pixel of vertical blanking: downstream motion updates off-screen
    assign vga.ref_tick = tick && (px == 10'd0) && (y_ext == V_VIS);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a shrunken DIV=2 raster
// for whole-frame behaviour, and a DIV=1 build.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen u_a (.clk(clk), .rst(rst_a), .vga(if_a));

    // 15 x 10 raster: hsync x 10..12, vsync y 7..8, ref_tick at (0,6)
    vga_sync_gen #(
        .DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_b (.clk(clk), .rst(rst_b), .vga(if_b));

    // 800 x 7 raster, ref_tick at (0,4)
    vga_sync_gen #(
        .DIV(1), .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (.clk(clk), .rst(rst_c), .vga(if_c));

    typedef struct {
        int unsigned n;
        logic        rst;
        logic        tick;
        int unsigned x;
        int unsigned y;
        logic        hs;
        logic        vs;
        logic        von;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned hs_low;
        int unsigned von_cnt;
        int unsigned vs_low;
        int unsigned ref_cnt;
        int unsigned ref_e[2];
        logic        prev_ref;

        vecs[0]  = '{3,    1'b1, 1'b0, 0,   0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,    1'b0, 1'b0, 0,   0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{2,    1'b0, 1'b1, 0,   0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1,    1'b0, 1'b0, 1,   0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{3,    1'b0, 1'b1, 1,   0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1,    1'b0, 1'b0, 2,   0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{2551, 1'b0, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1,    1'b0, 1'b0, 640, 0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{63,   1'b0, 1'b1, 655, 0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1,    1'b0, 1'b0, 656, 0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{383,  1'b0, 1'b1, 751, 0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1,    1'b0, 1'b0, 752, 0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{191,  1'b0, 1'b1, 799, 0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1,    1'b0, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1};

        // Default build: reset release and first line
        for (int i = 0; i < 14; i++) begin
            rst_a = vecs[i].rst;
            step(vecs[i].n);
            check($sformatf("v%0d.tick", i), int'(if_a.tick), int'(vecs[i].tick));
            check($sformatf("v%0d.x", i), int'(if_a.pixel_x), vecs[i].x);
            check($sformatf("v%0d.y", i), int'(if_a.pixel_y), vecs[i].y);
            check($sformatf("v%0d.hsync", i), int'(if_a.hsync), int'(vecs[i].hs));
            check($sformatf("v%0d.vsync", i), int'(if_a.vsync), int'(vecs[i].vs));
            check($sformatf("v%0d.video_on", i), int'(if_a.video_on), int'(vecs[i].von));
            check($sformatf("v%0d.ref_tick", i), int'(if_a.ref_tick), 0);
            check($sformatf("v%0d.frame", i), int'(if_a.frame), 0);
        end

        // Second line: hsync and video_on duty over exactly one line
        hs_low  = 0;
        von_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            step(1);
            if (!if_a.hsync) hs_low++;
            if (if_a.video_on) von_cnt++;
        end
        check("line.hsync_low_clocks", hs_low, 384);
        check("line.video_on_clocks", von_cnt, 2560);
        check("line.x_end", int'(if_a.pixel_x), 0);
        check("line.y_end", int'(if_a.pixel_y), 2);

        // Mid-line reset at (300,2) with div_cnt=2
        step(1202);
        check("mid.x", int'(if_a.pixel_x), 300);
        check("mid.y", int'(if_a.pixel_y), 2);
        check("mid.tick", int'(if_a.tick), 0);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        check("mid_rst.x", int'(if_a.pixel_x), 0);
        check("mid_rst.y", int'(if_a.pixel_y), 0);
        check("mid_rst.frame", int'(if_a.frame), 0);
        check("mid_rst.tick", int'(if_a.tick), 0);
        step(2);
        check("mid_rst.tick_e2", int'(if_a.tick), 0);
        step(1);
        check("mid_rst.tick_e3", int'(if_a.tick), 1);
        check("mid_rst.x_e3", int'(if_a.pixel_x), 0);
        step(1);
        check("mid_rst.x_e4", int'(if_a.pixel_x), 1);

        // Small raster: two frames, ref_tick spacing, vsync, triple wrap
        check("small.rst_ref", int'(if_b.ref_tick), 0);
        check("small.rst_frame", int'(if_b.frame), 0);
        check("small.rst_von", int'(if_b.video_on), 1);
        rst_b    = 1'b0;
        vs_low   = 0;
        hs_low   = 0;
        ref_cnt  = 0;
        ref_e[0] = 0;
        ref_e[1] = 0;
        prev_ref = 1'b0;
        for (int unsigned e = 1; e <= 600; e++) begin
            step(1);
            if (!if_b.vsync) vs_low++;
            if (!if_b.hsync) hs_low++;
            if (if_b.ref_tick) begin
                if (ref_cnt < 2) ref_e[ref_cnt] = e;
                ref_cnt++;
                check("small.ref_x", int'(if_b.pixel_x), 0);
                check("small.ref_y", int'(if_b.pixel_y), 6);
                check("small.ref_width", int'(prev_ref), 0);
            end
            prev_ref = if_b.ref_tick;
            if (e == 599) begin
                check("wrap_pre.x", int'(if_b.pixel_x), 14);
                check("wrap_pre.y", int'(if_b.pixel_y), 9);
                check("wrap_pre.frame", int'(if_b.frame), 1);
                check("wrap_pre.tick", int'(if_b.tick), 1);
            end
        end
        check("wrap_post.x", int'(if_b.pixel_x), 0);
        check("wrap_post.y", int'(if_b.pixel_y), 0);
        check("wrap_post.frame", int'(if_b.frame), 2);
        check("small.ref_count", ref_cnt, 2);
        check("small.ref_first", ref_e[0], 181);
        check("small.ref_period", ref_e[1] - ref_e[0], 300);
        check("small.vsync_low_clocks", vs_low, 120);
        check("small.hsync_low_clocks", hs_low, 120);

        // DIV=1 build
        check("div1.rst_tick", int'(if_c.tick), 1);
        check("div1.rst_x", int'(if_c.pixel_x), 0);
        rst_c = 1'b0;
        step(799);
        check("div1.x799", int'(if_c.pixel_x), 799);
        check("div1.y0", int'(if_c.pixel_y), 0);
        check("div1.tick", int'(if_c.tick), 1);
        step(1);
        check("div1.wrap_x", int'(if_c.pixel_x), 0);
        check("div1.wrap_y", int'(if_c.pixel_y), 1);
        step(2399);
        check("div1.ref_before", int'(if_c.ref_tick), 0);
        step(1);
        check("div1.ref", int'(if_c.ref_tick), 1);
        check("div1.ref_x", int'(if_c.pixel_x), 0);
        check("div1.ref_y", int'(if_c.pixel_y), 4);
        check("div1.ref_von", int'(if_c.video_on), 0);
        step(1);
        check("div1.ref_after", int'(if_c.ref_tick), 0);
        check("div1.ref_after_x", int'(if_c.pixel_x), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480 VGA Pong display. It divides the system clock into a pixel-rate strobe and runs the horizontal and vertical scan counters. From those counters it produces `hsync`, `vsync`, `video_on`, `pixel_x` and `pixel_y`, plus a once-per-frame `ref_tick`. It sits directly upstream of `pixel_generator`, which consumes `tick`, `ref_tick`, `video_on`, `pixel_x` and `pixel_y`; the sync pair goes straight to the VGA connector.

## Interface
Parameters:
- `DIV`, 4: system clocks per pixel (100 MHz to 25 MHz); legal range 1..16.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `video_on` out 1: high when the current pixel is in the visible area.
- `tick` out 1: pixel strobe, one `clk` wide.
- `ref_tick` out 1: frame strobe, one `clk` wide, once per frame.
- `pixel_x` out 10: horizontal counter, 0..H_TOTAL-1.
- `pixel_y` out 10: vertical counter, 0..V_TOTAL-1.
- `frame` out 8: frame counter, wraps at 256.

## Operation
- Derived constants:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (default 525).
  - Both must be ≤ 1024.
- Divider:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `tick` = (`div_cnt` == DIV-1), decoded combinationally.
  - When DIV=1, `tick` is held high continuously.
- Horizontal counter: on a clock with `tick`=1, `pixel_x` increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - On a clock with `tick`=1 and `pixel_x`==H_TOTAL-1, `pixel_y` increments.
  - At V_TOTAL-1 it wraps to 0, and `frame` increments at the same time (modulo 256).
  - Both counters hold on clocks where `tick`=0.
- Decodes, all combinational from the counter registers, so they are always aligned with `pixel_x`/`pixel_y`:
  - `video_on` = (`pixel_x` < H_DISP) && (`pixel_y` < V_DISP).
  - `hsync` = 0 iff H_DISP+H_FP ≤ `pixel_x` < H_DISP+H_FP+H_SYNC.
  - `vsync` = 0 iff V_DISP+V_FP ≤ `pixel_y` < V_DISP+V_FP+V_SYNC.
  - `ref_tick` = `tick` && (`pixel_x`==0) && (`pixel_y`==V_DISP). This is exactly one `clk` per frame, at the first pixel of vertical blanking, so object motion downstream updates while the frame is not being drawn.
- Reset (`rst`=1 at a `clk` edge): `div_cnt`, `pixel_x`, `pixel_y` and `frame` all go to 0.
- Output values while in reset and immediately after it:
  - `tick`=0 (1 if DIV=1), `ref_tick`=0.
  - `video_on`=1, since (0,0) is a visible pixel.
  - `hsync`=1, `vsync`=1.
  - `frame`=0.
- Reset asserted mid-frame discards the scan position at the next edge. There is no partial-line completion. `rst` overrides `tick`.

## Timing
- All registers update on `posedge clk`. There is no handshake; downstream samples outputs on clocks where `tick`=1.
- After `rst` falls, the first `tick` is high in the DIV-th `clk` period. `pixel_x` becomes 1 at the end of that period.
- Fixed periods, at defaults:
  - One line = H_TOTAL·DIV clocks = 3200.
  - One frame = H_TOTAL·V_TOTAL·DIV clocks = 1 680 000.
  - `ref_tick` period equals the frame period exactly.
- `hsync` low for H_SYNC·DIV = 384 clocks per line; `vsync` low for V_SYNC lines = 6400 clocks per frame.
- Simultaneous wraps: at (H_TOTAL-1, V_TOTAL-1) with `tick`=1, `pixel_x`, `pixel_y` and `frame` all update on the same edge, giving (0, 0, frame+1).
- Latency from a counter change to any decode output is zero clocks (combinational).

## Test plan
- Reset release: hold `rst` for 3 clocks, then release → `tick` high only on clocks 4, 8, 12…; `pixel_x` reads 1 after clock 4; `hsync`=`vsync`=1 and `video_on`=1 throughout.
- Line timing: run one full line →
  - `pixel_x` wraps 799→0 and `pixel_y` goes 0→1.
  - `video_on` falls at `pixel_x`=640.
  - `hsync` low for `pixel_x` 656..751 (384 clocks).
- Frame timing: run 2 frames →
  - `vsync` low for `pixel_y` 490..491.
  - `ref_tick` seen exactly twice, 1 680 000 clocks apart, each at (0,480), each 1 clock wide.
  - `frame` reads 2.
- Triple wrap: preload position by running to (799, 524) → next `tick` edge gives (0, 0) and `frame` +1 in the same clock.
- Mid-frame reset: assert `rst` for 1 clock at (300, 200) with `div_cnt`=2 → next cycle shows (0, 0), `frame`=0, `tick`=0; the next `tick` follows 4 clocks later.
- DIV=1 build: `tick` constantly 1; a line lasts 800 clocks; `ref_tick` is 1 clock at (0,480).
